// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: read, reserve and write/retire channels.
interface reg_file_sb_if #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned OVF_CNT_W = 8
);
    logic                 RegWrite;
    logic                 overflow;
    logic [ADDR_W-1:0]    Wr;
    logic [DATA_W-1:0]    Write_data;
    logic [ADDR_W-1:0]    Rd1;
    logic [ADDR_W-1:0]    Rd2;
    logic [DATA_W-1:0]    Rd1_out;
    logic [DATA_W-1:0]    Rd2_out;
    logic                 Rsv_en;
    logic [ADDR_W-1:0]    Rsv_addr;
    logic                 Rd1_busy;
    logic                 Rd2_busy;
    logic [OVF_CNT_W-1:0] Ovf_cnt;

    modport master (
        output RegWrite, overflow, Wr, Write_data, Rd1, Rd2, Rsv_en, Rsv_addr,
        input  Rd1_out, Rd2_out, Rd1_busy, Rd2_busy, Ovf_cnt
    );

    modport slave (
        input  RegWrite, overflow, Wr, Write_data, Rd1, Rd2, Rsv_en, Rsv_addr,
        output Rd1_out, Rd2_out, Rd1_busy, Rd2_busy, Ovf_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file: two async read ports, one sync write port, optional write bypass,
// per-register busy scoreboard for RAW detection and a saturating counter of overflow-dropped writes.
module reg_file_sb #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned INIT_MODE = 1,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam bit          BYP_EN   = (BYPASS != 0);
    localparam bit          INIT_IDX = (INIT_MODE != 0);

    logic [DATA_W-1:0]    regs [DEPTH];
    logic [DEPTH-1:1]     busy_q;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    logic              wr_valid_c;
    logic              commit_c;
    logic              suppress_c;
    logic              resolve1_c;
    logic              resolve2_c;
    logic [DEPTH-1:0]  busy_all_c;
    logic [DATA_W-1:0] rd1_data_c;
    logic [DATA_W-1:0] rd2_data_c;

    // Writes to register 0 are discarded entirely; overflow turns a write into a retire-only event.
    assign wr_valid_c = bus.RegWrite && (bus.Wr != '0);
    assign commit_c   = wr_valid_c && !bus.overflow;
    assign suppress_c = wr_valid_c && bus.overflow;

    // A read port whose register is retiring this cycle sees the value resolving now.
    assign resolve1_c = BYP_EN && wr_valid_c && (bus.Wr == bus.Rd1);
    assign resolve2_c = BYP_EN && wr_valid_c && (bus.Wr == bus.Rd2);

    assign busy_all_c = {busy_q, 1'b0};

    always_comb begin
        rd1_data_c = '0;
        rd2_data_c = '0;
        if (bus.Rd1 != '0) begin
            rd1_data_c = (resolve1_c && !bus.overflow) ? bus.Write_data : regs[bus.Rd1];
        end
        if (bus.Rd2 != '0) begin
            rd2_data_c = (resolve2_c && !bus.overflow) ? bus.Write_data : regs[bus.Rd2];
        end
    end

    assign bus.Rd1_out  = rd1_data_c;
    assign bus.Rd2_out  = rd2_data_c;
    assign bus.Rd1_busy = (bus.Rd1 != '0) && busy_all_c[bus.Rd1] && !resolve1_c;
    assign bus.Rd2_busy = (bus.Rd2 != '0) && busy_all_c[bus.Rd2] && !resolve2_c;
    assign bus.Ovf_cnt  = ovf_cnt_q;

    // Data array; register 0 only ever holds zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= (INIT_IDX && (i != 0)) ? DATA_W'(i) : '0;
            end
        end else if (commit_c) begin
            regs[bus.Wr] <= bus.Write_data;
        end
    end

    // Scoreboard: a new reservation outranks a same-cycle retire of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (bus.Rsv_en && (bus.Rsv_addr == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_valid_c && (bus.Wr == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Suppressed-write counter, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (suppress_c && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
        end
    end
endmodule
